// File: rtl/orb_window_gen_if.sv
// Pixel-in / window-out bundle for the sliding-window generator.
// master drives the raster stream; slave is the window generator.
interface orb_window_gen_if #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int WIN    = 31,
  parameter int DW     = 8
) ();
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic                   pixel_valid;
  logic [DW-1:0]          pixel;
  logic                   frame_start;
  logic                   frame_end;

  logic                   win_valid;
  logic [WIN*WIN*DW-1:0]  window;
  logic [XW-1:0]          center_x;
  logic [YW-1:0]          center_y;
  logic                   win_start;
  logic                   win_end;
  logic                   frame_err;

  modport master (
    output pixel_valid, pixel, frame_start, frame_end,
    input  win_valid, window, center_x, center_y, win_start, win_end, frame_err
  );

  modport slave (
    input  pixel_valid, pixel, frame_start, frame_end,
    output win_valid, window, center_x, center_y, win_start, win_end, frame_err
  );
endinterface

// File: rtl/orb_window_gen.sv
// Streaming WIN x WIN sliding-window generator with column-organised line memory.
// States: IDLE = waiting for a start pixel | RUN = inside a frame, counting pixels.
module orb_window_gen #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int WIN    = 31,
  parameter int DW     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  orb_window_gen_if.slave  bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int R  = (WIN - 1) / 2;
  localparam int CW = (WIN - 1) * DW;
  localparam int WW = WIN * WIN * DW;

  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_FIRST = XW'(WIN - 1);
  localparam logic [YW-1:0] Y_FIRST = YW'(WIN - 1);
  localparam logic [XW-1:0] X_R     = XW'(R);
  localparam logic [YW-1:0] Y_R     = YW'(R);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, px;
  logic [YW-1:0]   y_q, y_d, py;
  logic            proc, at_last, win_ok;

  logic            valid_q, start_q, end_q, err_q;
  logic            valid_d, start_d, end_d, err_d;
  logic [XW-1:0]   cx_q, cx_d;
  logic [YW-1:0]   cy_q, cy_d;

  logic [CW-1:0]   mem [WIDTH];
  logic [CW-1:0]   rd_word;
  logic [WIN*DW-1:0] col;
  logic [WW-1:0]   win_q, win_d;

  // A start pixel restarts the coordinates even mid-frame.
  assign proc    = bus.pixel_valid && (bus.frame_start || state_q == RUN);
  assign px      = bus.frame_start ? '0 : x_q;
  assign py      = bus.frame_start ? '0 : y_q;
  assign at_last = (px == X_LAST) && (py == Y_LAST);
  assign win_ok  = proc && (px >= X_FIRST) && (py >= Y_FIRST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (proc) begin
      if (bus.frame_end || at_last) begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end else begin
        state_d = RUN;
        if (px == X_LAST) begin
          x_d = '0;
          y_d = py + YW'(1);
        end else begin
          x_d = px + XW'(1);
          y_d = py;
        end
      end
    end
  end

  always_comb begin
    valid_d = win_ok;
    start_d = win_ok && (px == X_FIRST) && (py == Y_FIRST);
    end_d   = win_ok && at_last;
    err_d   = proc && ((bus.frame_start && state_q == RUN) ||
                       (bus.frame_end && !at_last) ||
                       (!bus.frame_end && at_last));
    cx_d    = win_ok ? px - X_R : cx_q;
    cy_d    = win_ok ? py - Y_R : cy_q;
  end

  // Column vector: oldest line at the low slots, the incoming pixel on top.
  assign rd_word = mem[px];
  assign col     = {bus.pixel, rd_word};

  always_ff @(posedge clk) begin
    if (rst_n && proc) mem[px] <= col[WIN*DW-1:DW];
  end

  for (genvar r = 0; r < WIN; r++) begin : g_row
    assign win_d[r*WIN*DW +: WIN*DW] = {col[r*DW +: DW], win_q[r*WIN*DW + DW +: (WIN-1)*DW]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      win_q   <= '0;
    end else begin
      valid_q <= valid_d;
      start_q <= start_d;
      end_q   <= end_d;
      err_q   <= err_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      if (proc) win_q <= win_d;
    end
  end

  assign bus.win_valid = valid_q;
  assign bus.win_start = start_q;
  assign bus.win_end   = end_q;
  assign bus.frame_err = err_q;
  assign bus.center_x  = cx_q;
  assign bus.center_y  = cy_q;
  assign bus.window    = win_q;
endmodule

// File: tb/tb_orb_window_gen.sv
// Directed bench: WIN=3 and WIN=5 generators on an 8x6 raster share one pixel stream.
module tb_orb_window_gen;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic clk, rst_n;
  logic pv, ps, pe;
  logic [DW-1:0] pd;
  int errors = 0;
  int checks = 0;

  orb_window_gen_if #(.WIDTH(W), .HEIGHT(H), .WIN(3), .DW(DW)) bus3 ();
  orb_window_gen_if #(.WIDTH(W), .HEIGHT(H), .WIN(5), .DW(DW)) bus5 ();

  assign bus3.pixel_valid = pv;
  assign bus3.pixel       = pd;
  assign bus3.frame_start = ps;
  assign bus3.frame_end   = pe;
  assign bus5.pixel_valid = pv;
  assign bus5.pixel       = pd;
  assign bus5.frame_start = ps;
  assign bus5.frame_end   = pe;

  orb_window_gen #(.WIDTH(W), .HEIGHT(H), .WIN(3), .DW(DW)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  orb_window_gen #(.WIDTH(W), .HEIGHT(H), .WIN(5), .DW(DW)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_i(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] exp_win(input int w, input int seed, input int cx, input int cy);
    logic [255:0] v;
    int r;
    v = '0;
    r = (w - 1) / 2;
    for (int rr = 0; rr < w; rr++)
      for (int cc = 0; cc < w; cc++)
        v[(rr*w+cc)*8 +: 8] = 8'(seed + 8*(cy - r + rr) + (cx - r + cc));
    return v;
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s, input logic e);
    pv = v; pd = d; ps = s; pe = e;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dut(input int w, input int seed, input int x, input int y,
                         input bit exp_err, input bit at_last,
                         input logic v, input logic st, input logic en, input logic er,
                         input int cx, input int cy, input logic [255:0] win, output bit got);
    string t;
    bit ev;
    t  = $sformatf("w%0d(%0d,%0d)", w, x, y);
    ev = (x >= w - 1) && (y >= w - 1);
    chk_i({t, " valid"}, int'(v), int'(ev));
    chk_i({t, " frame_err"}, int'(er), int'(exp_err));
    if (ev) begin
      chk_i({t, " center_x"}, cx, x - (w - 1) / 2);
      chk_i({t, " center_y"}, cy, y - (w - 1) / 2);
      chk_w({t, " window"}, win, exp_win(w, seed, x - (w - 1) / 2, y - (w - 1) / 2));
      chk_i({t, " start"}, int'(st), int'(x == w - 1 && y == w - 1));
      chk_i({t, " end"}, int'(en), int'(at_last));
    end else begin
      chk_i({t, " no_marker"}, int'(st | en), 0);
    end
    got = v;
  endtask

  task automatic run_frame(input int seed, input bit gaps, input int n_pix, input bit err_first, input bit do_end);
    int wins3, wins5, lcx, lcy;
    bit held3, g3, g5;
    logic [255:0] last3;
    wins3 = 0; wins5 = 0; held3 = 0; lcx = 0; lcy = 0; last3 = '0;
    for (int i = 0; i < n_pix; i++) begin
      int x, y;
      bit at_last, e, ee;
      x = i % W;
      y = i / W;
      at_last = (x == W - 1) && (y == H - 1);
      e  = (i == n_pix - 1) && do_end;
      ee = (i == 0 && err_first) || (e && !at_last) || (!e && at_last);
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          drive(1'b0, 8'h00, 1'b0, 1'b0);
          step();
          chk_i("gap_valid", int'(bus3.win_valid | bus5.win_valid), 0);
          chk_i("gap_pulses", int'(bus3.win_start | bus3.win_end | bus3.frame_err |
                                   bus5.win_start | bus5.win_end | bus5.frame_err), 0);
          if (held3) begin
            chk_w("hold_window", 256'(bus3.window), last3);
            chk_i("hold_cx", int'(bus3.center_x), lcx);
            chk_i("hold_cy", int'(bus3.center_y), lcy);
          end
        end
      end
      drive(1'b1, 8'(seed + 8*y + x), i == 0, e);
      step();
      chk_dut(3, seed, x, y, ee, at_last, bus3.win_valid, bus3.win_start, bus3.win_end, bus3.frame_err,
              int'(bus3.center_x), int'(bus3.center_y), 256'(bus3.window), g3);
      chk_dut(5, seed, x, y, ee, at_last, bus5.win_valid, bus5.win_start, bus5.win_end, bus5.frame_err,
              int'(bus5.center_x), int'(bus5.center_y), 256'(bus5.window), g5);
      if (g3) wins3++;
      if (g5) wins5++;
      held3 = (x >= 2) && (y >= 2);
      last3 = exp_win(3, seed, x - 1, y - 1);
      lcx = x - 1;
      lcy = y - 1;
      if (seed == 0 && x == 2 && y == 2) chk_w("first_row0", 256'(bus3.window[23:0]), 256'(24'h020100));
      if (seed == 0 && at_last) chk_i("last_center_tap", int'(bus3.window[39:32]), 38);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    if (n_pix == W * H) begin
      chk_i("window_count3", wins3, 24);
      chk_i("window_count5", wins5, 8);
    end
  endtask

  task automatic ignored(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      step();
      chk_i("ignored_valid", int'(bus3.win_valid | bus5.win_valid), 0);
      chk_i("ignored_err", int'(bus3.frame_err | bus5.frame_err), 0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic all_zero(input string tag);
    chk_w({tag, " window3"}, 256'(bus3.window), '0);
    chk_w({tag, " window5"}, 256'(bus5.window), '0);
    chk_i({tag, " center"}, int'(bus3.center_x) + int'(bus3.center_y) +
                            int'(bus5.center_x) + int'(bus5.center_y), 0);
    chk_i({tag, " pulses"}, int'(bus3.win_valid | bus3.win_start | bus3.win_end | bus3.frame_err |
                                 bus5.win_valid | bus5.win_start | bus5.win_end | bus5.frame_err), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    all_zero("reset");
    rst_n = 1'b1;
    ignored(2);
    chk_w("idle_window", 256'(bus3.window), '0);

    run_frame(0, 1'b0, W*H, 1'b0, 1'b1);
    run_frame(100, 1'b1, W*H, 1'b0, 1'b1);
    run_frame(0, 1'b1, W*H, 1'b0, 1'b1);

    // Restart at (3,2): first 19 pixels of an aborted frame, then a new frame.
    run_frame(7, 1'b0, 19, 1'b0, 1'b0);
    run_frame(50, 1'b0, W*H, 1'b1, 1'b1);

    // Early end at (5,3), then unstarted pixels are ignored.
    run_frame(20, 1'b0, 30, 1'b0, 1'b1);
    ignored(3);

    // Last pixel without end strobe.
    run_frame(30, 1'b1, W*H, 1'b0, 1'b0);
    ignored(1);

    drive(1'b1, 8'h05, 1'b1, 1'b1);
    step();
    chk_i("start_end err", int'(bus3.frame_err & bus5.frame_err), 1);
    chk_i("start_end valid", int'(bus3.win_valid | bus5.win_valid), 0);
    ignored(1);

    // Reset on the pixel that would produce a window.
    run_frame(0, 1'b0, 26, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 8'(8*3 + 2), 1'b0, 1'b0);
    step();
    all_zero("midreset");
    rst_n = 1'b1;
    ignored(2);
    chk_w("post_reset_window", 256'(bus3.window), '0);
    run_frame(0, 1'b1, W*H, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/orb_window_gen.md
# orb_window_gen

Parametrised streaming sliding-window generator for the ORB feature pipeline. It accepts a raster pixel stream with frame start/end strobes and buffers WIN-1 lines internally in a column-organised ring memory. For every interior pixel it emits a complete WIN×WIN neighbourhood with its centre coordinates, a valid strobe and frame markers. It generalises the fixed 31×31, 640-wide BRIEF window logic in width, height, window size and pixel depth, and adds explicit window-valid gating, first/last-window markers and malformed-frame detection.

## Interface

Parameters:
- WIDTH, 640, pixels per line (≥ WIN).
- HEIGHT, 480, lines per frame (≥ WIN).
- WIN, 31, window edge; odd, 3..31; R = (WIN-1)/2.
- DW, 8, bits per pixel.
- XW = $clog2(WIDTH), YW = $clog2(HEIGHT) (derived; not overridable).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_pixel_valid  in  1  pixel accept strobe; nothing advances when low.
- i_pixel  in  DW  pixel data.
- i_start  in  1  qualifies first pixel of a frame (with i_pixel_valid).
- i_end  in  1  qualifies last pixel of a frame (with i_pixel_valid).
- o_win_valid  out  1  o_window/o_center_* valid this cycle.
- o_window  out  WIN*WIN*DW  slice [(r*WIN+c)*DW +: DW] = pixel (cx-R+c, cy-R+r); r=0 top, c=0 left.
- o_center_x  out  XW  window centre column.
- o_center_y  out  YW  window centre row.
- o_start  out  1  first window of frame (with o_win_valid).
- o_end  out  1  last window of frame (with o_win_valid).
- o_frame_err  out  1  one-cycle pulse on malformed frame.

## Operation

- States: IDLE, RUN. IDLE→RUN on accepted pixel with i_start. RUN→IDLE on accepted i_end, or on an accepted pixel at (WIDTH-1, HEIGHT-1) without i_end (error).
- Input counters x_in/y_in: set to (0,0) on start pixel; x_in increments per accepted pixel and wraps at WIDTH-1 with y_in+1.
- Line memory: WIDTH entries of (WIN-1)*DW bits, indexed by column. On an accepted pixel at column x: read mem[x] (oldest→newest), form column vector {mem[x], i_pixel} (WIN pixels), write mem[x] ← {mem[x] minus oldest, i_pixel}. One read and one write per accepted pixel, same address.
- Window register: WIN columns; the new column is shifted in at the right, and the leftmost column is dropped.
- Window valid when the newest pixel satisfies x_in ≥ WIN-1 and y_in ≥ WIN-1. Centre = (x_in-R, y_in-R). Stale memory or window columns from a previous line or frame are never emitted, because the gating excludes them.
- o_start asserts with centre (R,R). o_end asserts with centre (WIDTH-1-R, HEIGHT-1-R).
- Windows per frame = (WIDTH-WIN+1)*(HEIGHT-WIN+1).
- Pixels accepted in IDLE without i_start are ignored.
- i_start while in RUN: o_frame_err pulses, counters restart at (0,0), the frame continues as new, and no o_end is issued for the aborted frame.
- Accepted i_end not at (WIDTH-1, HEIGHT-1): o_frame_err pulses, state→IDLE, and no further windows are emitted.
- Accepted i_start and i_end on the same pixel: i_start handling first, then i_end handling. Result: o_frame_err, state IDLE.
- Coordinate arithmetic is unsigned, XW/YW bits; no intermediate exceeds WIDTH-1/HEIGHT-1.

## Timing

- Latency: window for newest pixel accepted at cycle t appears registered at cycle t+1. o_win_valid, o_start, o_end and o_center_* are aligned.
- o_win_valid, o_start, o_end and o_frame_err are single-cycle pulses, high only in the cycle after an accepted pixel. When i_pixel_valid is low, they are 0 in the following cycle; o_window and o_center_* hold their values.
- o_frame_err is registered, one cycle after the offending accepted pixel.
- Reset (i_rst_n low at a clock edge), including mid-frame:
  - state IDLE, counters 0.
  - Window register cleared; o_window = 0, o_center_x = 0, o_center_y = 0.
  - o_win_valid = 0, o_start = 0, o_end = 0, o_frame_err = 0.
  - Line memory is not cleared.
- Throughput: one pixel per cycle sustained; i_pixel_valid may toggle arbitrarily.

## Test plan

- WIDTH=8, HEIGHT=6, WIN=3, DW=8; pixel value = 8*y+x, valid every cycle → exactly 24 windows; first centre (1,1) with o_start and o_window row0 = {0,1,2}; last centre (6,4) with o_end and centre tap 38.
- Same frame with i_pixel_valid toggling 1-0-0-1 pseudo-randomly → identical window sequence; outputs hold during gaps; no extra pulses.
- WIN=5, second frame with different data directly after first → no window containing first-frame pixels; first window centre (2,2) equals new data.
- i_start re-asserted at (3,2) mid-frame → o_frame_err pulse one cycle later; next o_start at centre (1,1) of the new frame; no o_end for the aborted frame.
- i_end at (5,3) → o_frame_err; no o_win_valid until the next i_start; pixels without i_start ignored.
- Reset at the pixel that would produce a window mid-frame → next cycle all outputs 0, state IDLE; a subsequent full frame yields 24 correct windows.
